// File: rtl/port_io_controller.sv
// Memory-mapped GPIO port: per-bit direction, 2-flop input sync, registered bus reads.
// Define PORT_IO_IRQ_EN to build the edge detector, IRQ_EN/IRQ_STATUS registers and irq.
module port_io_controller #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned IRQ_EDGE = 0
) (
  input  logic             sys_clk,
  input  logic             rst_sync,
  input  logic             ce,
  input  logic             wr,
  input  logic [3:0]       address,
  input  logic [31:0]      data_in,
  output logic [31:0]      data_out,
  output logic             irq,
  inout  wire  [WIDTH-1:0] port_io
);

  localparam logic [1:0] ADDR_DATA       = 2'd0;
  localparam logic [1:0] ADDR_CONFIG     = 2'd1;
  localparam logic [1:0] ADDR_IRQ_EN     = 2'd2;
  localparam logic [1:0] ADDR_IRQ_STATUS = 2'd3;

  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] config_q, config_d;
  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [31:0]      data_out_q, data_out_d;
  logic [WIDTH-1:0] rd_val;
  logic [31:0]      rd_word;
  logic [WIDTH-1:0] wdata;
  logic [1:0]       reg_sel;
  logic             wr_en, rd_en;
  logic             unused_addr_lsb;

  assign reg_sel         = address[3:2];
  assign unused_addr_lsb = ^address[1:0];
  assign wr_en           = ce & wr;
  assign rd_en           = ce & ~wr;
  assign wdata           = data_in[WIDTH-1:0];

  // Output-configured pins drive their DATA bit; all others are released.
  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    assign port_io[i] = config_q[i] ? data_q[i] : 1'bz;
  end

  always_comb begin
    data_d   = data_q;
    config_d = config_q;
    if (wr_en) begin
      if (reg_sel == ADDR_DATA)   data_d   = wdata;
      if (reg_sel == ADDR_CONFIG) config_d = wdata;
    end
  end

`ifdef PORT_IO_IRQ_EN
  logic [WIDTH-1:0] sync3_q;
  logic [WIDTH-1:0] irq_en_q, irq_en_d;
  logic [WIDTH-1:0] irq_status_q, irq_status_d;
  logic [WIDTH-1:0] edge_hit, w1c_mask;
  logic             irq_q, irq_d;

  // sync3 follows sync2 every cycle, so a CONFIG write also reloads it and
  // edges are only ever evaluated on bits currently configured as inputs.
  always_comb begin
    if (IRQ_EDGE != 0) edge_hit = ~sync2_q & sync3_q & ~config_q;
    else               edge_hit = sync2_q & ~sync3_q & ~config_q;

    w1c_mask = (wr_en && reg_sel == ADDR_IRQ_STATUS) ? wdata : '0;
    irq_en_d = (wr_en && reg_sel == ADDR_IRQ_EN) ? wdata : irq_en_q;
    // A new edge wins over a coincident clear.
    irq_status_d = (irq_status_q & ~w1c_mask) | edge_hit;
    irq_d        = |(irq_status_q & irq_en_q);
  end

  always_ff @(posedge sys_clk) begin
    if (rst_sync) begin
      sync3_q      <= '0;
      irq_en_q     <= '0;
      irq_status_q <= '0;
      irq_q        <= 1'b0;
    end else begin
      sync3_q      <= sync2_q;
      irq_en_q     <= irq_en_d;
      irq_status_q <= irq_status_d;
      irq_q        <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  logic unused_irq_edge;
  assign unused_irq_edge = (IRQ_EDGE != 0);
  assign irq             = 1'b0;
`endif

  always_comb begin
    rd_val = '0;
    case (reg_sel)
      ADDR_DATA:       rd_val = (data_q & config_q) | (sync2_q & ~config_q);
      ADDR_CONFIG:     rd_val = config_q;
`ifdef PORT_IO_IRQ_EN
      ADDR_IRQ_EN:     rd_val = irq_en_q;
      ADDR_IRQ_STATUS: rd_val = irq_status_q;
`endif
      default:         rd_val = '0;
    endcase
    rd_word             = '0;
    rd_word[WIDTH-1:0]  = rd_val;
    data_out_d          = rd_en ? rd_word : data_out_q;
  end

  always_ff @(posedge sys_clk) begin
    if (rst_sync) begin
      data_q     <= '0;
      config_q   <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      data_out_q <= '0;
    end else begin
      data_q     <= data_d;
      config_q   <= config_d;
      sync1_q    <= port_io;
      sync2_q    <= sync1_q;
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;

endmodule

// File: tb/tb_port_io_controller.sv
// Self-checking bench for port_io_controller; IRQ scenarios follow PORT_IO_IRQ_EN.
module tb_port_io_controller;

  logic        clk;
  logic        rst;
  logic        ce;
  logic        wr;
  logic [3:0]  address;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        irq;
  wire  [31:0] port_io;
  logic [31:0] pin_drv;
  logic [31:0] pin_oe;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got;
  logic [31:0] exp;

  for (genvar i = 0; i < 32; i++) begin : g_drv
    assign port_io[i] = pin_oe[i] ? pin_drv[i] : 1'bz;
  end

  port_io_controller #(
    .WIDTH   (32),
    .IRQ_EDGE(0)
  ) dut (
    .sys_clk (clk),
    .rst_sync(rst),
    .ce      (ce),
    .wr      (wr),
    .address (address),
    .data_in (data_in),
    .data_out(data_out),
    .irq     (irq),
    .port_io (port_io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    ce = 1'b1; wr = 1'b1; address = a; data_in = d;
    @(negedge clk);
    ce = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    ce = 1'b1; wr = 1'b0; address = a;
    @(negedge clk);
    ce = 1'b0;
    d = data_out;
  endtask

  task automatic wait_cycles(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    wait_cycles(3);
    rst = 1'b0;
    n_checks++;
    if (data_out !== 32'h0) begin
      n_errors++; $display("FAIL reset_data_out: got %h required %h", data_out, 32'h0);
    end
    n_checks++;
    if (irq !== 1'b0) begin
      n_errors++; $display("FAIL reset_irq: got %b required 0", irq);
    end
    exp_q.push_back(32'h0);
    bus_read(4'h4, got);
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin
      n_errors++; $display("FAIL reset_config: got %h required %h", got, exp);
    end
    exp_q.push_back(32'h0000_0005);
    bus_read(4'h0, got);
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin
      n_errors++; $display("FAIL reset_data_pins: got %h required %h", got, exp);
    end
  endtask

  task automatic test_bus_hold;
    // ce low: data_out holds and writes are ignored.
    exp = 32'h0000_0005;
    @(negedge clk);
    wr = 1'b1; address = 4'h4; data_in = 32'hFFFF_FFFF;
    wait_cycles(3);
    wr = 1'b0;
    n_checks++;
    if (data_out !== exp) begin
      n_errors++; $display("FAIL hold_data_out: got %h required %h", data_out, exp);
    end
    exp_q.push_back(32'h0);
    bus_read(4'h6, got);  // low address bits are ignored
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin
      n_errors++; $display("FAIL ce_low_write: got %h required %h", got, exp);
    end
  endtask

  task automatic test_direction;
    pin_oe  = 32'h0000_FFFF;
    pin_drv = 32'h0000_0007;
    bus_write(4'h4, 32'hFFFF_0000);
    bus_write(4'h0, 32'hABCD_1234);
    #1;
    n_checks++;
    if (port_io[31:16] !== 16'hABCD) begin
      n_errors++; $display("FAIL pins_out_high: got %h required %h", port_io[31:16], 16'hABCD);
    end
    n_checks++;
    if (port_io[15:0] !== 16'h0007) begin
      n_errors++; $display("FAIL pins_in_low_released: got %h required %h", port_io[15:0],
                           16'h0007);
    end
    exp_q.push_back(32'hABCD_0007);
    bus_read(4'h0, got);
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin
      n_errors++; $display("FAIL data_mixed_read: got %h required %h", got, exp);
    end
    // Input bits of DATA were stored too: make all outputs while bench agrees.
    pin_drv = 32'h0000_1234;
    wait_cycles(3);
    bus_write(4'h4, 32'hFFFF_FFFF);
    exp_q.push_back(32'hABCD_1234);
    bus_read(4'h0, got);
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin
      n_errors++; $display("FAIL data_stored_inputs: got %h required %h", got, exp);
    end
    bus_write(4'h4, 32'hFFFF_0000);
    pin_drv = 32'h0000_0000;
    wait_cycles(4);
  endtask

`ifdef PORT_IO_IRQ_EN
  task automatic test_irq_enable;
    logic seen;
    bus_write(4'hC, 32'hFFFF_FFFF);
    bus_write(4'h8, 32'h0000_0004);
    pin_drv[2] = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 4 && !seen; c++) begin
      @(negedge clk);
      if (irq === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      n_errors++; $display("FAIL irq_rise_latency: got irq=%b required 1 within 4 cycles", irq);
    end
    exp_q.push_back(32'h0000_0004);
    bus_read(4'hC, got);
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin
      n_errors++; $display("FAIL irq_status_set: got %h required %h", got, exp);
    end
    bus_write(4'hC, 32'h0000_0004);
    n_checks++;
    if (irq !== 1'b1) begin
      n_errors++; $display("FAIL irq_w1c_one_cycle: got %b required 1", irq);
    end
    @(negedge clk);
    n_checks++;
    if (irq !== 1'b0) begin
      n_errors++; $display("FAIL irq_w1c_two_cycles: got %b required 0", irq);
    end
  endtask

  task automatic test_irq_pending;
    bus_write(4'h8, 32'h0);
    pin_drv[1] = 1'b1;
    wait_cycles(4);
    exp_q.push_back(32'h0000_0002);
    bus_read(4'hC, got);
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin
      n_errors++; $display("FAIL status_without_en: got %h required %h", got, exp);
    end
    n_checks++;
    if (irq !== 1'b0) begin
      n_errors++; $display("FAIL irq_masked: got %b required 0", irq);
    end
    bus_write(4'h8, 32'h0000_0002);
    n_checks++;
    if (irq !== 1'b0) begin
      n_errors++; $display("FAIL irq_en_same_cycle: got %b required 0", irq);
    end
    @(negedge clk);
    n_checks++;
    if (irq !== 1'b1) begin
      n_errors++; $display("FAIL irq_en_next_cycle: got %b required 1", irq);
    end
  endtask

  task automatic test_w1c_race;
    bus_write(4'hC, 32'h0000_0002);
    bus_write(4'h8, 32'h0000_0004);
    pin_drv[2] = 1'b0;
    wait_cycles(4);
    pin_drv[2] = 1'b1;
    wait_cycles(4);
    pin_drv[2] = 1'b0;
    wait_cycles(4);
    // Raise the pin, then time the clear onto the edge-detect cycle.
    pin_drv[2] = 1'b1;
    wait_cycles(2);
    ce = 1'b1; wr = 1'b1; address = 4'hC; data_in = 32'h0000_0004;
    @(negedge clk);
    ce = 1'b0; wr = 1'b0;
    n_checks++;
    if (irq !== 1'b1) begin
      n_errors++; $display("FAIL race_irq_held: got %b required 1", irq);
    end
    exp_q.push_back(32'h0000_0004);
    bus_read(4'hC, got);
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin
      n_errors++; $display("FAIL race_set_wins: got %h required %h", got, exp);
    end
    n_checks++;
    if (irq !== 1'b1) begin
      n_errors++; $display("FAIL race_irq_after: got %b required 1", irq);
    end
  endtask
`else
  task automatic test_irq_disabled;
    bus_write(4'h8, 32'hFFFF_FFFF);
    bus_write(4'hC, 32'hFFFF_FFFF);
    exp_q.push_back(32'h0);
    bus_read(4'h8, got);
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin
      n_errors++; $display("FAIL irq_en_absent: got %h required %h", got, exp);
    end
    pin_drv[3:0] = 4'hF;
    wait_cycles(5);
    exp_q.push_back(32'h0);
    bus_read(4'hC, got);
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin
      n_errors++; $display("FAIL irq_status_absent: got %h required %h", got, exp);
    end
    n_checks++;
    if (irq !== 1'b0) begin
      n_errors++; $display("FAIL irq_tied_low: got %b required 0", irq);
    end
  endtask
`endif

  task automatic test_dir_change_and_reset;
    pin_drv[0] = 1'b1;
    wait_cycles(4);
    bus_write(4'h0, 32'hFFFF_0001);
    bus_write(4'h4, 32'hFFFF_0001);
    wait_cycles(4);
    bus_write(4'hC, 32'hFFFF_FFFF);
    bus_write(4'h4, 32'hFFFF_0000);
    wait_cycles(5);
    exp_q.push_back(32'h0);
    bus_read(4'hC, got);
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin
      n_errors++; $display("FAIL no_spurious_edge: got %h required %h", got, exp);
    end
    bus_write(4'h8, 32'h0000_000F);
    // Reset with a concurrent CONFIG write; reset must win.
    @(negedge clk);
    rst = 1'b1; ce = 1'b1; wr = 1'b1; address = 4'h4; data_in = 32'hFFFF_FFFF;
    @(negedge clk);
    rst = 1'b0; ce = 1'b0; wr = 1'b0;
    n_checks++;
    if (data_out !== 32'h0) begin
      n_errors++; $display("FAIL midreset_data_out: got %h required %h", data_out, 32'h0);
    end
    n_checks++;
    if (irq !== 1'b0) begin
      n_errors++; $display("FAIL midreset_irq: got %b required 0", irq);
    end
    pin_oe  = 32'hFFFF_FFFF;
    pin_drv = 32'h5A5A_A5A5;
    #1;
    n_checks++;
    if (port_io !== 32'h5A5A_A5A5) begin
      n_errors++; $display("FAIL midreset_pins_released: got %h required %h", port_io,
                           32'h5A5A_A5A5);
    end
    exp_q.push_back(32'h0);
    bus_read(4'hC, got);
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin
      n_errors++; $display("FAIL midreset_status: got %h required %h", got, exp);
    end
    exp_q.push_back(32'h0);
    bus_read(4'h8, got);
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin
      n_errors++; $display("FAIL midreset_irq_en: got %h required %h", got, exp);
    end
    exp_q.push_back(32'h0);
    bus_read(4'h4, got);
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin
      n_errors++; $display("FAIL midreset_config: got %h required %h", got, exp);
    end
    exp_q.push_back(32'h5A5A_A5A5);
    bus_read(4'h0, got);
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin
      n_errors++; $display("FAIL midreset_data: got %h required %h", got, exp);
    end
  endtask

  initial begin
    rst     = 1'b1;
    ce      = 1'b0;
    wr      = 1'b0;
    address = 4'h0;
    data_in = 32'h0;
    pin_oe  = 32'hFFFF_FFFF;
    pin_drv = 32'h0000_0005;
    test_reset();
    test_bus_hold();
    test_direction();
`ifdef PORT_IO_IRQ_EN
    test_irq_enable();
    test_irq_pending();
    test_w1c_race();
`else
    test_irq_disabled();
`endif
    test_dir_change_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/port_io_controller.md
PORT_IO_CONTROLLER -- requirements
Module: port_io_controller

Interface
REQ-001 Parameter: WIDTH, 32, number of bidirectional port bits.
REQ-002 Parameter: IRQ_EDGE, 0, 0 = rising-edge capture, 1 = falling-edge capture.
REQ-003 sys_clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_sync  input  1  reset, synchronous, active-high.
REQ-005 ce  input  1  register access enable from the uC bus.
REQ-006 wr  input  1  1 = write and 0 = read; qualified by ce.
REQ-007 address  input  4  register select; bits [3:2] are decoded and bits [1:0] are ignored.
REQ-008 data_in  input  32  write data from the uC.
REQ-009 data_out  output  32  read data to the uC.
REQ-010 irq  output  1  interrupt request to the uC, level, active-high.
REQ-011 port_io  inout  WIDTH  external pins, for example buttons or LEDs.

Function
REQ-012 Register map by address[3:2]:
- 0 = DATA
- 1 = CONFIG (bit=1 makes the pin an output)
- 2 = IRQ_EN
- 3 = IRQ_STATUS
REQ-013 Each output pin SHALL drive its DATA register bit.
- Each pin whose CONFIG bit is 0 SHALL be released to high-Z.
- This SHALL be decided per bit.
REQ-014 Input path: every pin SHALL pass through a 2-flop synchronizer.
- Synchronized value sync2 is available 2 cycles after the pin changes.
REQ-015 DATA read, per bit: output bit returns the DATA register value; input bit returns sync2.
REQ-016 Write (ce=1, wr=1) SHALL update the selected register at the next edge.
- Only bits [WIDTH-1:0] are used.
- A DATA write SHALL store all bits, including bits currently configured as inputs.
REQ-017 Read (ce=1, wr=0): data_out SHALL be registered, valid 1 cycle after the access cycle.
- data_out bits above WIDTH-1 SHALL read 0.
REQ-018 data_out SHALL hold its last value when ce=0.
REQ-019 Edge detector: sync3 is a one-cycle-delayed copy of sync2.
- Rising edge = sync2 & ~sync3.
- Falling edge = ~sync2 & sync3.
- Only input bits SHALL be evaluated.
REQ-020 A detected edge on bit n SHALL set IRQ_STATUS[n] in the same cycle edge is computed.
- IRQ_STATUS[n] SHALL be set regardless of IRQ_EN[n].
REQ-021 IRQ_STATUS SHALL be write-1-to-clear.
- If a clear and a new edge coincide on the same bit, the set SHALL win.
REQ-022 irq SHALL be registered and equal OR(IRQ_STATUS & IRQ_EN), delayed 1 cycle.
REQ-023 Changing a bit from output to input SHALL NOT generate a spurious edge.
- sync3 for that bit SHALL be loaded with sync2 on the CONFIG write cycle.

Reset
REQ-024 With rst_sync=1 at a clock edge, all of the following SHALL be cleared to 0 and SHALL be 0 the cycle after:
- DATA, CONFIG, IRQ_EN, IRQ_STATUS
- the synchronizer flops
- data_out and irq
REQ-025 After reset all pins SHALL be high-Z (all inputs).
REQ-026 An access with rst_sync=1 SHALL be ignored; reset has priority over writes.

Configuration
REQ-027 Macro PORT_IO_IRQ_EN.
- Defined: the edge detector, IRQ_EN, IRQ_STATUS and irq SHALL be implemented as specified above.
- Undefined: none of that logic SHALL exist; irq SHALL be tied to 0, and addresses 2 and 3 SHALL read 0 and ignore writes.

Verification
REQ-028 Reset, then read CONFIG and DATA with pins driven 0x0000_0005 -> after sync latency, CONFIG reads 0 and DATA reads 0x0000_0005.
REQ-029 Write CONFIG=0xFFFF_0000, then DATA=0xABCD_1234 -> port_io[31:16] = 0xABCD and port_io[15:0] = Z; a DATA read with the bench driving 0x0007 on the low half returns 0xABCD_0007.
REQ-030 Macro defined, IRQ_EN=0x4, bench raises port_io[2] -> IRQ_STATUS=0x4 and irq=1 within 4 cycles of the pin change; write IRQ_STATUS=0x4 -> irq=0 two cycles later.
REQ-031 IRQ_EN=0, pin 1 rises -> IRQ_STATUS=0x2 and irq stays 0; then write IRQ_EN=0x2 -> irq=1 one cycle after IRQ_EN updates.
REQ-032 A W1C to IRQ_STATUS bit 2 in the same cycle as a new rising edge on bit 2 -> bit 2 remains 1 and irq remains 1.
REQ-033 Drive port_io[0]=1 with bit 0 configured as output, then write CONFIG bit 0 to 0 -> no IRQ_STATUS bit set; apply rst_sync mid-operation -> all registers are 0 and all pins are Z on the next cycle.
